bp_debounce_irq_ctrl: RTL and testbench
=======================================

// Module: bp_debounce_irq_ctrl
// PURPOSE
//  Avalon-MM slave controller for the board push-buttons. Sits between the raw button
//  pins and the Nios II bus.
//  Synchronises and debounces each button, then captures press edges. Raises a maskable
//  interrupt so software never polls or samples raw bounce.
// PARAMETERS
//  N_BTN       2       number of push-buttons (1..32)
//  DEB_CYCLES  50000   stable cycles required to accept a new level (1 ms @ 50 MHz), >=2
//  CNT_W       16      debounce counter width, 2**CNT_W > DEB_CYCLES
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      asynchronous active-low reset
//  chipselect  in   1      Avalon slave select
//  address     in   2      register word address
//  write_n     in   1      Avalon write strobe, active-low
//  writedata   in   32     write data
//  readdata    out  32     registered read data
//  in_port     in   N_BTN  raw button pins, active-low (0 = pressed)
//  irq         out  1      interrupt request, active-high, level
// BEHAVIOUR
//  Interface: reset reset_n, asynchronous, active-low; clock clk.
//  Reset values:
//   - readdata = 0, irq = 0, mask = 0, edge = 0.
//   - Sync flops = all-1; deb_state = all-1 (released); counters = 0; every FSM in STABLE.
//   - Reset asserted mid-debounce aborts the count; no edge is recorded.
//  Synchroniser: 2-FF per bit; sync = second stage; 2-cycle pin-to-sync latency.
//  Per-button FSM, states STABLE and CHECK:
//   - STABLE: sync == deb_state -> stay, cnt = 0. sync != deb_state -> CHECK, cnt = 1.
//   - CHECK: sync == deb_state (bounce back) -> STABLE, cnt = 0.
//   - CHECK: else if cnt == DEB_CYCLES-1 -> deb_state <= sync, STABLE, cnt = 0.
//   - CHECK: else cnt++. The counter never wraps.
//   - A level change is accepted only after DEB_CYCLES consecutive sync samples of the
//     new value.
//  Edge capture:
//   - edge[i] is set in the same cycle deb_state[i] goes 1->0 (press).
//   - Release (0->1) sets nothing.
//   - edge[i] is sticky until software clears it.
//  Register map (word address; bits above N_BTN-1 read 0, writes ignored):
//   - 0 DATA: deb_state, RO.
//   - 1 MASK: irq mask, RW.
//   - 2 EDGE: captured presses; writing 1 clears a bit, writing 0 has no effect.
//   - 3 RAW: sync (undebounced), RO.
//  Write accepted when chipselect=1 and write_n=0.
//   - Takes effect at the next posedge.
//  Simultaneous EDGE clear and new press on the same bit: the set wins, bit stays 1.
//  Read:
//   - Every cycle, readdata <= zero-extended mux(address).
//   - Registered, 1-cycle latency, no wait states. Independent of chipselect.
//  irq:
//   - Registered: irq <= |(edge & mask).
//   - Rises 1 cycle after the edge bit sets or the mask bit is set.
//   - Falls 1 cycle after the clearing write.
// TESTING (bench uses DEB_CYCLES=4)
//  - Reset: hold reset_n=0 with in_port=2'b00.
//    -> readdata=0, irq=0. After release, DATA reads 2'b11 until 2+4 cycles of stable 0.
//  - Clean press on bit0: in_port 11->10, held.
//    -> DATA=2'b10 and EDGE=2'b01 exactly 2+4 cycles after the pin change. irq stays 0
//    (MASK=0).
//  - Bounce: bit1 toggles 1,0,1,0 every 2 cycles, then holds 0.
//    -> no DATA change during the bounce. DATA[1]=0 only 4 stable cycles after the last
//    toggle. EDGE[1] set once.
//  - IRQ path: write MASK=3, press bit0.
//    -> irq=1 one cycle after EDGE[0]=1. Write EDGE=1 -> irq=0 one cycle after the write.
//  - Collision: write EDGE=2'b01 in the same cycle a new bit0 press is accepted.
//    -> EDGE[0] remains 1, irq stays 1.
//  - Release and mid-op reset:
//    - Release bit0 -> DATA[0]=1, EDGE unchanged.
//    - Assert reset_n at cnt=2 during a press -> EDGE=0, DATA=2'b11, FSM restarts
//      after reset.

Source files
------------

// File: rtl/bp_debounce_irq_ctrl.sv
// Push-button controller: 2-FF sync, per-button debounce FSM, sticky press capture,
// maskable level interrupt and a 4-word Avalon-MM register window.
module bp_debounce_irq_ctrl #(
  parameter int unsigned N_BTN      = 2,
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [N_BTN-1:0] in_port,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_RAW  = 2'd3;

  typedef enum logic {ST_STABLE = 1'b0, ST_CHECK = 1'b1} deb_st_e;

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] deb_q, deb_d;
  logic [N_BTN-1:0] edge_q, edge_d;
  logic [N_BTN-1:0] mask_q, mask_d;
  logic [N_BTN-1:0] press_c;
  logic [N_BTN-1:0] clr_c;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];
  deb_st_e          st_q  [N_BTN];
  deb_st_e          st_d  [N_BTN];
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr_c;
  logic             unused_wdata_c;

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      deb_q      <= '1;
      edge_q     <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < int'(N_BTN); i++) begin
        st_q[i]  <= ST_STABLE;
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      for (int i = 0; i < int'(N_BTN); i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Per-button debounce FSM; a press is a 1->0 acceptance of the debounced level
  always_comb begin
    deb_d   = deb_q;
    press_c = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      case (st_q[i])
        ST_STABLE: begin
          if (sync2_q[i] != deb_q[i]) begin
            st_d[i]  = ST_CHECK;
            cnt_d[i] = CNT_W'(1);
          end else begin
            cnt_d[i] = '0;
          end
        end
        ST_CHECK: begin
          if (sync2_q[i] == deb_q[i]) begin
            st_d[i]  = ST_STABLE;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            deb_d[i]   = sync2_q[i];
            press_c[i] = ~sync2_q[i];
            st_d[i]    = ST_STABLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          st_d[i]  = ST_STABLE;
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  // Register file: writes, sticky edges (set beats clear), read mux and irq
  always_comb begin
    wr_c   = chipselect & ~write_n;
    mask_d = mask_q;
    clr_c  = '0;
    if (wr_c && (address == ADDR_MASK)) mask_d = writedata[N_BTN-1:0];
    if (wr_c && (address == ADDR_EDGE)) clr_c  = writedata[N_BTN-1:0];
    edge_d = (edge_q & ~clr_c) | press_c;
    irq_d  = |(edge_q & mask_q);
    case (address)
      ADDR_DATA: readdata_d = 32'(deb_q);
      ADDR_MASK: readdata_d = 32'(mask_q);
      ADDR_EDGE: readdata_d = 32'(edge_q);
      ADDR_RAW:  readdata_d = 32'(sync2_q);
      default:   readdata_d = '0;
    endcase
  end

  assign unused_wdata_c = ^writedata;
  assign readdata       = readdata_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_bp_debounce_irq_ctrl.sv
// Directed bench for bp_debounce_irq_ctrl with DEB_CYCLES=4: vector table plus
// a hand-written mid-debounce asynchronous reset sequence.
module tb_bp_debounce_irq_ctrl;

  logic        clk;
  logic        reset_n;
  logic        chipselect;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  in_port;
  logic        irq;

  int unsigned n_tests;
  int unsigned n_fail;

  bp_debounce_irq_ctrl #(
    .N_BTN      (2),
    .DEB_CYCLES (4),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One step: drive inputs at a negedge, let n posedges pass, compare at the next negedge
  typedef struct {
    logic        rst_n;
    logic [1:0]  inp;
    logic [1:0]  addr;
    logic        cs;
    logic        wr;
    logic [31:0] wdata;
    int unsigned n;
    logic [31:0] rd;
    logic        irq;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst_n, input logic [1:0] inp, input logic [1:0] addr,
                     input logic cs, input logic wr, input logic [31:0] wdata,
                     input int unsigned n, input logic [31:0] rd, input logic exp_irq);
    vec_t v;
    v.rst_n = rst_n; v.inp = inp; v.addr = addr; v.cs = cs; v.wr = wr;
    v.wdata = wdata; v.n = n; v.rd = rd; v.irq = exp_irq;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    in_port    = 2'b00;

    //   rst in     addr cs wr wdata         n  rd  irq
    // reset with both pins low, then both presses accepted after 2+4 cycles
    add(0, 2'b00, 2'd0, 0, 0, 32'h0,        3, 32'h0, 0);
    add(1, 2'b00, 2'd0, 0, 0, 32'h0,        6, 32'h3, 0);
    add(1, 2'b00, 2'd0, 0, 0, 32'h0,        1, 32'h0, 0);
    add(1, 2'b00, 2'd2, 0, 0, 32'h0,        1, 32'h3, 0);
    // release both: DATA back to 11, EDGE untouched, then clear EDGE
    add(1, 2'b11, 2'd0, 0, 0, 32'h0,        6, 32'h0, 0);
    add(1, 2'b11, 2'd0, 0, 0, 32'h0,        1, 32'h3, 0);
    add(1, 2'b11, 2'd2, 0, 0, 32'h0,        1, 32'h3, 0);
    add(1, 2'b11, 2'd2, 1, 1, 32'h3,        1, 32'h3, 0);
    add(1, 2'b11, 2'd2, 0, 0, 32'h0,        1, 32'h0, 0);
    // clean press on bit0
    add(1, 2'b10, 2'd0, 0, 0, 32'h0,        6, 32'h3, 0);
    add(1, 2'b10, 2'd0, 0, 0, 32'h0,        1, 32'h2, 0);
    add(1, 2'b10, 2'd2, 0, 0, 32'h0,        1, 32'h1, 0);
    add(1, 2'b10, 2'd3, 0, 0, 32'h0,        1, 32'h2, 0);
    // bounce on bit1: 0,1 for 2 cycles each then held 0
    add(1, 2'b00, 2'd0, 0, 0, 32'h0,        2, 32'h2, 0);
    add(1, 2'b10, 2'd0, 0, 0, 32'h0,        2, 32'h2, 0);
    add(1, 2'b00, 2'd0, 0, 0, 32'h0,        6, 32'h2, 0);
    add(1, 2'b00, 2'd0, 0, 0, 32'h0,        1, 32'h0, 0);
    add(1, 2'b00, 2'd2, 0, 0, 32'h0,        1, 32'h3, 0);
    add(1, 2'b00, 2'd2, 1, 1, 32'h3,        1, 32'h3, 0);
    add(1, 2'b00, 2'd2, 0, 0, 32'h0,        1, 32'h0, 0);
    // MASK write (upper bits dropped), write without chipselect ignored
    add(1, 2'b00, 2'd1, 1, 1, 32'hFFFFFFFF, 1, 32'h0, 0);
    add(1, 2'b00, 2'd1, 0, 0, 32'h0,        1, 32'h3, 0);
    add(1, 2'b00, 2'd1, 0, 1, 32'h0,        1, 32'h3, 0);
    add(1, 2'b00, 2'd1, 0, 0, 32'h0,        1, 32'h3, 0);
    // release bit0: DATA[0]=1, no edge
    add(1, 2'b01, 2'd0, 0, 0, 32'h0,        6, 32'h0, 0);
    add(1, 2'b01, 2'd0, 0, 0, 32'h0,        1, 32'h1, 0);
    add(1, 2'b01, 2'd2, 0, 0, 32'h0,        1, 32'h0, 0);
    // press bit0 with mask: irq one cycle after EDGE[0] sets, falls one after clear
    add(1, 2'b00, 2'd2, 0, 0, 32'h0,        6, 32'h0, 0);
    add(1, 2'b00, 2'd2, 0, 0, 32'h0,        1, 32'h1, 1);
    add(1, 2'b00, 2'd2, 1, 1, 32'h1,        1, 32'h1, 1);
    add(1, 2'b00, 2'd2, 0, 0, 32'h0,        1, 32'h0, 0);
    // collision: EDGE clear on the very edge the bit0 press is accepted
    add(1, 2'b01, 2'd0, 0, 0, 32'h0,        7, 32'h1, 0);
    add(1, 2'b00, 2'd2, 0, 0, 32'h0,        5, 32'h0, 0);
    add(1, 2'b00, 2'd2, 1, 1, 32'h1,        1, 32'h0, 0);
    add(1, 2'b00, 2'd2, 0, 0, 32'h0,        1, 32'h1, 1);
    add(1, 2'b00, 2'd2, 0, 0, 32'h0,        1, 32'h1, 1);
    add(1, 2'b00, 2'd0, 0, 0, 32'h0,        1, 32'h0, 1);
    // release bit0 again, EDGE[0] kept so irq stays high
    add(1, 2'b01, 2'd0, 0, 0, 32'h0,        7, 32'h1, 1);

    @(negedge clk);
    for (int k = 0; k < vq.size(); k++) begin
      reset_n    = vq[k].rst_n;
      in_port    = vq[k].inp;
      address    = vq[k].addr;
      chipselect = vq[k].cs;
      write_n    = ~vq[k].wr;
      writedata  = vq[k].wdata;
      repeat (vq[k].n) @(negedge clk);
      chk($sformatf("vec%0d readdata", k), readdata, vq[k].rd);
      chk($sformatf("vec%0d irq", k), 32'(irq), 32'(vq[k].irq));
    end

    // mid-debounce reset: press bit0, reach cnt=2, reset asynchronously
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    in_port    = 2'b00;
    repeat (4) @(negedge clk);
    chk("middeb data_held", readdata, 32'h1);
    chk("middeb irq_held", 32'(irq), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst readdata", readdata, 32'h0);
    chk("async_rst irq", 32'(irq), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("restart data_before", readdata, 32'h3);
    @(negedge clk);
    chk("restart data_after", readdata, 32'h0);
    address = 2'd2;
    @(negedge clk);
    chk("restart edge", readdata, 32'h3);
    chk("restart irq_masked", 32'(irq), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
